// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - two-player battleship turn sequencer with ack timeout
module game_sequencer #(
    parameter int WIN_HITS    = 17,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       place_done,
    input  logic       shot_valid,
    input  logic       fire_ack,
    input  logic       fire_hit,
    output logic       start,
    output logic [1:0] place_en,
    output logic       active_player,
    output logic       fire_req,
    output logic [4:0] p1_hits,
    output logic [4:0] p2_hits,
    output logic [1:0] winner,
    output logic       timeout_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_PLACE1 = 3'd1,
        ST_PLACE2 = 3'd2,
        ST_TURN1  = 3'd3,
        ST_FIRE1  = 3'd4,
        ST_TURN2  = 3'd5,
        ST_FIRE2  = 3'd6,
        ST_OVER   = 3'd7
    } state_t;

    localparam logic [4:0] WIN_LIM = 5'(WIN_HITS);
    localparam logic [7:0] ACK_LIM = 8'(ACK_TIMEOUT);

    // Enter-key synchronizer and edge detector
    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       armed_q;
    logic [1:0] fill_q;
    logic       enter_rise;

    // Registered FSM state and outputs
    state_t     state_q, state_d;
    logic       start_q;
    logic [1:0] place_en_q;
    logic       fire_req_q;
    logic       active_q, active_d;
    logic [4:0] p1_hits_q, p1_hits_d;
    logic [4:0] p2_hits_q, p2_hits_d;
    logic [1:0] winner_q, winner_d;
    logic       terr_q, terr_d;
    logic [7:0] tmo_q, tmo_d;

    // Saturating hit increments and timeout increment
    logic [4:0] p1_inc;
    logic [4:0] p2_inc;
    logic [4:0] p1_after;
    logic [4:0] p2_after;
    logic [7:0] tmo_inc;

    // Two-flop synchronizer; edge detection stays disarmed until the
    // synchronized level has been seen low after reset, so a key held
    // through reset does not count as a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= enter;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign enter_rise = sync2_q & ~prev_q & armed_q;

    assign p1_inc   = (p1_hits_q == 5'd31) ? 5'd31 : p1_hits_q + 5'd1;
    assign p2_inc   = (p2_hits_q == 5'd31) ? 5'd31 : p2_hits_q + 5'd1;
    assign p1_after = fire_hit ? p1_inc : p1_hits_q;
    assign p2_after = fire_hit ? p2_inc : p2_hits_q;
    assign tmo_inc  = tmo_q + 8'd1;

    // Next-state logic: each state only reacts to the event legal for it
    always_comb begin
        state_d   = state_q;
        p1_hits_d = p1_hits_q;
        p2_hits_d = p2_hits_q;
        winner_d  = winner_q;
        tmo_d     = tmo_q;
        terr_d    = 1'b0;
        case (state_q)
            ST_START: begin
                if (enter_rise) state_d = ST_PLACE1;
            end
            ST_PLACE1: begin
                if (place_done) state_d = ST_PLACE2;
            end
            ST_PLACE2: begin
                if (place_done) state_d = ST_TURN1;
            end
            ST_TURN1: begin
                if (shot_valid) begin
                    state_d = ST_FIRE1;
                    tmo_d   = 8'd0;
                end
            end
            ST_TURN2: begin
                if (shot_valid) begin
                    state_d = ST_FIRE2;
                    tmo_d   = 8'd0;
                end
            end
            ST_FIRE1: begin
                if (fire_ack) begin
                    p1_hits_d = p1_after;
                    tmo_d     = 8'd0;
                    if (p1_after == WIN_LIM) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d = ST_TURN2;
                    end
                end else if (tmo_inc == ACK_LIM) begin
                    state_d = ST_TURN1;
                    terr_d  = 1'b1;
                    tmo_d   = 8'd0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_FIRE2: begin
                if (fire_ack) begin
                    p2_hits_d = p2_after;
                    tmo_d     = 8'd0;
                    if (p2_after == WIN_LIM) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d = ST_TURN1;
                    end
                end else if (tmo_inc == ACK_LIM) begin
                    state_d = ST_TURN2;
                    terr_d  = 1'b1;
                    tmo_d   = 8'd0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_OVER: begin
                if (enter_rise) begin
                    state_d   = ST_START;
                    winner_d  = 2'b00;
                    p1_hits_d = 5'd0;
                    p2_hits_d = 5'd0;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    // Shooter identity follows the turn states and holds elsewhere
    always_comb begin
        active_d = active_q;
        case (state_d)
            ST_TURN1, ST_FIRE1: active_d = 1'b0;
            ST_TURN2, ST_FIRE2: active_d = 1'b1;
            default:            active_d = active_q;
        endcase
    end

    // State register with outputs decoded from the next state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_START;
            start_q    <= 1'b1;
            place_en_q <= 2'b00;
            fire_req_q <= 1'b0;
            active_q   <= 1'b0;
            p1_hits_q  <= 5'd0;
            p2_hits_q  <= 5'd0;
            winner_q   <= 2'b00;
            terr_q     <= 1'b0;
            tmo_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            start_q    <= (state_d == ST_START);
            place_en_q <= {state_d == ST_PLACE2, state_d == ST_PLACE1};
            fire_req_q <= (state_d == ST_FIRE1) || (state_d == ST_FIRE2);
            active_q   <= active_d;
            p1_hits_q  <= p1_hits_d;
            p2_hits_q  <= p2_hits_d;
            winner_q   <= winner_d;
            terr_q     <= terr_d;
            tmo_q      <= tmo_d;
        end
    end

    assign state         = state_q;
    assign start         = start_q;
    assign place_en      = place_en_q;
    assign fire_req      = fire_req_q;
    assign active_player = active_q;
    assign p1_hits       = p1_hits_q;
    assign p2_hits       = p2_hits_q;
    assign winner        = winner_q;
    assign timeout_err   = terr_q;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter WIN_HITS, default 17, meaning hits required to win (5+4+3+3+2 fleet), legal 1..31.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning cycles to wait for fire_ack before abort, legal 1..255.
REQ-003 The block SHALL have port clk, input, 1, system clock with all state changing on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, with reset asynchronous and active-low.
REQ-005 The block SHALL have port enter, input, 1, raw Enter-key level that is asynchronous to clk.
REQ-006 The block SHALL have port place_done, input, 1, one-cycle pulse when the placing player's fleet is complete.
REQ-007 The block SHALL have port shot_valid, input, 1, one-cycle pulse when the active player commits a target.
REQ-008 The block SHALL have port fire_ack, input, 1, one-cycle pulse from the board datapath completing a shot.
REQ-009 The block SHALL have port fire_hit, input, 1, shot result, sampled only with fire_ack.
REQ-010 The block SHALL have port start, output, 1, high only in state START (start-screen display).
REQ-011 The block SHALL have port place_en, output, 2, one-hot placement enable, where bit0 is P1 and bit1 is P2.
REQ-012 The block SHALL have port active_player, output, 1, 0=P1 and 1=P2, giving the shooter in TURN/FIRE states.
REQ-013 The block SHALL have port fire_req, output, 1, shot request to the datapath.
REQ-014 The block SHALL have port p1_hits and p2_hits, output, 5 each, hits scored by each player.
REQ-015 The block SHALL have port winner, output, 2, where 00 is none, 01 is P1 and 10 is P2.
REQ-016 The block SHALL have port timeout_err, output, 1, one-cycle pulse on ack timeout.
REQ-017 The block SHALL have port state, output, 3, encoded START=0, PLACE1=1, PLACE2=2, TURN1=3, FIRE1=4, TURN2=5, FIRE2=6, OVER=7.

Function
REQ-018 The block SHALL pass enter through a 2-flop synchronizer and derive enter_rise as a one-cycle pulse on a 0->1 transition of the synchronized signal, for 2-3 cycles of latency.
REQ-019 The block SHALL transition START->PLACE1 on enter_rise, and SHALL ignore enter_rise in every other state except OVER.
REQ-020 The block SHALL transition PLACE1->PLACE2 on place_done, and PLACE2->TURN1 on place_done.
REQ-021 The block SHALL set place_en to 01 in PLACE1, 10 in PLACE2, and 00 elsewhere.
REQ-022 The block SHALL transition TURNx->FIREx on shot_valid, and SHALL ignore shot_valid in all other states.
REQ-023 The block SHALL hold fire_req high for exactly the cycles spent in FIRE1/FIRE2, registered so that it rises the cycle after shot_valid.
REQ-024 The block SHALL treat fire_ack as valid only in FIREx, including fire_ack in the first FIRE cycle, and SHALL ignore fire_ack elsewhere.
REQ-025 On a valid fire_ack with fire_hit=1, the block SHALL increment the shooter's hit counter, saturating at 31.
REQ-026 On a valid fire_ack, if the updated shooter count equals WIN_HITS, the block SHALL go to OVER with winner set to the shooter; otherwise it SHALL go to the opponent's TURN, whether the shot hit or missed.
REQ-027 The block SHALL reload a timeout counter to 0 on entry to FIREx and increment it each FIRE cycle without fire_ack.
REQ-028 When the timeout counter reaches ACK_TIMEOUT, the block SHALL return to the same TURNx with counters unchanged and pulse timeout_err for one cycle.
REQ-029 The block SHALL set active_player to 0 in TURN1/FIRE1 and 1 in TURN2/FIRE2, and SHALL hold its previous value in other states.
REQ-030 In OVER, the block SHALL hold winner and both hit counters, and SHALL go to START on enter_rise.
REQ-031 On the OVER->START transition, the block SHALL clear winner, p1_hits and p2_hits.
REQ-032 When place_done and shot_valid arrive in the same cycle, the block SHALL act only on the event legal for the current state.

Reset
REQ-033 While reset=0, the block SHALL asynchronously force state=START, start=1, place_en=00, active_player=0, fire_req=0, p1_hits=p2_hits=0, winner=00, timeout_err=0, synchronizer flops=0 and timeout counter=0.
REQ-034 A reset asserted mid-operation, including in FIREx with fire_req=1, SHALL drop fire_req immediately and discard any in-flight shot.
REQ-035 After reset deasserts, an enter already held high SHALL NOT produce enter_rise until enter is released and pressed again.

Verification
REQ-036 Reset scenario: reset low, then high, with enter held high -> state=0 and start=1 persist; release and press enter -> state=1 within 3 cycles and place_en=01.
REQ-037 Full flow scenario: pulse place_done twice, then shot_valid -> state=4 and fire_req=1 one cycle later; fire_ack with fire_hit=0 -> state=5, active_player=1 and p1_hits=0.
REQ-038 Win scenario: with WIN_HITS=2, P1 hits, P2 misses, P1 hits -> state=7, winner=01, p1_hits=2; then enter press -> state=0 and all counters 0.
REQ-039 Timeout scenario: with ACK_TIMEOUT=4, shot_valid with no ack -> timeout_err pulses once, state returns to 3 and fire_req=0.
REQ-040 Spurious-event scenario: fire_ack in TURN1 and shot_valid in PLACE1 -> no state or counter change; fire_ack in the same cycle fire_req rises -> accepted.
REQ-041 Mid-shot reset scenario: reset pulse while state=6 -> fire_req=0 asynchronously and all outputs at reset values.
